// File: rtl/pipelined_ripple_adder_if.sv
// rtl/pipelined_ripple_adder_if.sv - operand/result handshake bundle for pipelined_ripple_adder
//
// Purpose: groups the input operand channel and the output result channel.
// Signals:
//   in_valid/in_ready : operand handshake (a, b, cin travel with it)
//   out_valid/out_ready : result handshake (sum, cout, dbg_c_last travel with it)
//   ovf : signed overflow, present only when PIPELINED_RIPPLE_ADDER_OVF_EN is defined
// Modports: slave = adder side, master = producer/consumer side.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             dbg_c_last;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, dbg_c_last, ovf
  );
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, dbg_c_last, ovf
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, dbg_c_last
  );
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, dbg_c_last
  );
`endif
endinterface

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - WIDTH-bit add with carry-in, carry chain split over STAGES clock stages
//
// Purpose: {cout,sum} = a + b + cin, one SLICE-bit piece of the carry chain resolved per stage,
// with valid/ready handshakes and full backpressure (global hold while the output is stalled).
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   io (slave) : in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout/dbg_c_last out
//   busy       : any stage holds valid data
// Optional: define PIPELINED_RIPPLE_ADDER_OVF_EN to add io.ovf (signed overflow, registered with sum).
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_ripple_adder_if.slave io,
  output logic                    busy
);
  localparam int SLICE = WIDTH / STAGES;

  // Per-stage state: operands travel along so later slices can be computed,
  // the partial sum accumulates resolved slices, carry out / carry in are kept per stage.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] ci_q, ci_d;

  logic             stall;
  logic [WIDTH-1:0] pa, pb, ps;
  logic             pc, pv;
  logic [SLICE:0]   part;
  int               km1;

  assign stall = vld_q[STAGES-1] && !io.out_ready;

  always_comb begin
    pa   = '0;
    pb   = '0;
    ps   = '0;
    pc   = 1'b0;
    pv   = 1'b0;
    part = '0;
    km1  = 0;
    vld_d = '0;
    c_d   = '0;
    ci_d  = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
      s_d[k] = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      km1 = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        pa = io.a;
        pb = io.b;
        pc = io.cin;
        pv = io.in_valid;
        ps = '0;
      end else begin
        pa = a_q[km1];
        pb = b_q[km1];
        pc = c_q[km1];
        pv = vld_q[km1];
        ps = s_q[km1];
      end
      part = {1'b0, pa[k*SLICE +: SLICE]} + {1'b0, pb[k*SLICE +: SLICE]} + {{SLICE{1'b0}}, pc};
      vld_d[k] = pv;
      a_d[k]   = pa;
      b_d[k]   = pb;
      ci_d[k]  = pc;
      c_d[k]   = part[SLICE];
      s_d[k]   = ps;
      s_d[k][k*SLICE +: SLICE] = part[SLICE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ci_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      ci_q  <= ci_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
    end
  end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  // After the loop pa/pb/part describe the MSB slice; the carry into the MSB
  // bit is recovered as a ^ b ^ sum at that bit.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = pa[WIDTH-1] ^ pb[WIDTH-1] ^ part[SLICE-1] ^ part[SLICE];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= ovf_d;
    end
  end

  assign io.ovf = ovf_q;
`endif

  assign io.in_ready   = !stall;
  assign io.out_valid  = vld_q[STAGES-1];
  assign io.sum        = s_q[STAGES-1];
  assign io.cout       = c_q[STAGES-1];
  assign io.dbg_c_last = ci_q[STAGES-1];
  assign busy          = |vld_q;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - scoreboard bench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;
  localparam int W = 16;
  localparam int S = 4;
  localparam int SL = W / S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.WIDTH(W)) io ();

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave),
    .busy (busy)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         dbg;
    logic         ovf;
    int           acc_cyc;
    int           acc_stalls;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    exp_t e;
    longint unsigned full, lowmask, low;
    full    = longint'(a) + longint'(b) + longint'(cin);
    lowmask = (64'd1 << (W - SL)) - 1;
    low     = (longint'(a) & lowmask) + (longint'(b) & lowmask) + longint'(cin);
    e.sum   = full[W-1:0];
    e.cout  = full[W];
    e.dbg   = low[W-SL];
    e.ovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.acc_cyc = 0;
    e.acc_stalls = 0;
    return e;
  endfunction

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    int   n;
    logic acc;
    exp_t e;
    n = 0;
    acc = 1'b0;
    io.a = a;
    io.b = b;
    io.cin = cin;
    io.in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = io.in_ready;
      if (acc) begin
        e = model(a, b, cin);
        e.acc_cyc = cyc;
        e.acc_stalls = stalls;
        q.push_back(e);
      end
      @(posedge clk);
      n++;
    end
    check("send_accepted", {31'b0, acc}, 32'd1);
    #1 io.in_valid = 1'b0;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks hold during stalls.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_dbg;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          check("stall_hold_valid", {31'b0, io.out_valid}, 32'd1);
          check("stall_hold_sum", {16'b0, io.sum}, {16'b0, prev_sum});
          check("stall_hold_cout", {31'b0, io.cout}, {31'b0, prev_cout});
          check("stall_hold_dbg", {31'b0, io.dbg_c_last}, {31'b0, prev_dbg});
        end
        if (io.out_valid && io.out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("sum", {16'b0, io.sum}, {16'b0, e.sum});
            check("cout", {31'b0, io.cout}, {31'b0, e.cout});
            check("dbg_c_last", {31'b0, io.dbg_c_last}, {31'b0, e.dbg});
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
            check("ovf", {31'b0, io.ovf}, {31'b0, e.ovf});
`endif
            if (e.acc_stalls == stalls)
              check("latency", cyc - e.acc_cyc, S);
          end
        end
        if (io.out_valid && !io.out_ready) begin
          stalls++;
          check("in_ready_low_on_stall", {31'b0, io.in_ready}, 32'd0);
        end
        prev_stall = io.out_valid && !io.out_ready;
        prev_sum   = io.sum;
        prev_cout  = io.cout;
        prev_dbg   = io.dbg_c_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) io.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_reset_state(string tag);
    check({tag, "_out_valid"}, {31'b0, io.out_valid}, 32'd0);
    check({tag, "_sum"}, {16'b0, io.sum}, 32'd0);
    check({tag, "_cout"}, {31'b0, io.cout}, 32'd0);
    check({tag, "_dbg"}, {31'b0, io.dbg_c_last}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.cin = 1'b0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_in_ready", {31'b0, io.in_ready}, 32'd1);
    @(posedge clk);
    #1 io.out_ready = 1'b1;

    // single ops and full carry ripple
    send(16'h0000, 16'h0000, 1'b0);
    drain(20);
    send(16'h1234, 16'h4321, 1'b1);
    drain(20);
    send(16'hFFFF, 16'h0001, 1'b0);
    drain(20);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    drain(20);
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    drain(20);
`endif

    // streaming
    for (int i = 0; i < 8; i++) send(16'(i * 16'h1111), 16'h0F0F, 1'(i & 1));
    drain(30);

    // backpressure
    io.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'hA000 + i * 16'h0123), 16'h6F00, 1'(i & 1));
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, io.in_ready}, 32'd0);
      check("bp_busy", {31'b0, busy}, 32'd1);
    end
    @(posedge clk);
    #1 io.out_ready = 1'b1;
    drain(30);

    // reset mid-operation discards in-flight results
    for (int i = 0; i < 3; i++) send(16'(16'h1000 * (i + 1)), 16'h0FFF, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midreset_in_ready", {31'b0, io.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(16'hBEEF, 16'h1111, 1'b0);
    drain(20);

    // randomized traffic with random output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain(2000);
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised successor to the team's 4-bit ripple-carry adder: WIDTH-bit add with carry-in, registered.
- Carry chain split into STAGES equal slices; one slice is resolved per clock stage.
- Valid/ready handshake on input and output with full backpressure.
- Sits in datapath arithmetic where a long combinational ripple chain breaks timing.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; slice width SLICE = WIDTH/STAGES; must be 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH
- cout  output  1  carry out of MSB
- dbg_c_last  output  1  carry into the MSB slice (debug, same timing as sum)
- busy  output  1  any stage holds valid data

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, sum=0, cout=0, dbg_c_last=0, busy=0. in_ready=1 in the first cycle after release.
- Transfer rules: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall (combinational). While stalled, every stage register holds, including data, carry and valid. Holding is global; no bubble collapsing.
- Stage k (0..STAGES-1):
  - Computes slice k of a+b plus carry from stage k-1; stage 0 uses cin.
  - Stores the SLICE sum bits and the carry out.
  - Passes the unprocessed upper slices of a/b and the lower result slices forward unchanged.
- Latency: exactly STAGES cycles from accept to out_valid with no stall. Throughput 1 result/cycle.
- Ordering: results leave in acceptance order. No drop, duplication or reorder under any out_ready pattern.
- Output stability: sum, cout and dbg_c_last are registered. They must not change while out_valid=1 and out_ready=0.
- Debug carry: dbg_c_last = carry into bit WIDTH-SLICE. For STAGES=1 it equals cin.
- Width rules:
  - Sum is WIDTH bits; overflow appears only on cout.
  - {cout,sum} == a+b+cin, computed at WIDTH+1 bits.
- Empty stage: invalid stages still clock data (don't-care) but never raise out_valid.
- Simultaneous events: accept and consume in the same cycle is legal, and the pipeline advances.
- busy = OR of all stage valid bits.
- Reset mid-operation: all in-flight results are discarded with no output. The first result after reset is the first operand accepted after reset.
- in_valid without in_ready: the source must hold its operands stable; the block samples only on transfer.

Optional Feature:
- Macro: PIPELINED_RIPPLE_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), registered alongside sum.
  - ovf = signed two's-complement overflow = carry into MSB XOR cout.
  - Reset value 0; held during stall like sum.
- Undefined: no ovf port and no overflow logic; the rest of the behaviour is identical.

Test Plan (WIDTH=16, STAGES=4):
- Reset: assert rst_n=0 mid-run -> immediately out_valid=0, sum=0, cout=0, busy=0. After release, in_ready=1.
- Single op: a=0x0000, b=0x0000, cin=0 accepted at cycle T -> out_valid at T+4, sum=0x0000, cout=0. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, dbg_c_last=1. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Streaming: 8 back-to-back ops (a=i*0x1111, b=0x0F0F, cin=i&1) with out_ready=1 -> 8 consecutive out_valid cycles, each result correct and in order.
- Backpressure: 4 ops in flight, out_ready=0 for 5 cycles -> in_ready=0; sum/cout stable. After release, all 4 results arrive in order with none lost.
- Overflow (macro defined): a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
